// File: rtl/tinker_regfile_sb.sv
// Shared register file with per-register busy scoreboard: NUM_RD combinational
// read ports with writeback bypass, one writeback port, issue-time busy marking.

module tinker_regfile_sb_rdport #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int AW       = 5
) (
  input  logic [AW-1:0]                    addr_i,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
  input  logic [NUM_REGS-1:0]              busy_i,
  input  logic                             wb_valid_i,
  input  logic [AW-1:0]                    wb_addr_i,
  input  logic [DATA_W-1:0]                wb_data_i,
  output logic [DATA_W-1:0]                data_o,
  output logic                             busy_o
);
  logic in_rng;

  always_comb begin
    in_rng = {1'b0, addr_i} < (AW+1)'(NUM_REGS);
    data_o = '0;
    busy_o = 1'b0;
    if (in_rng) begin
      // a same-cycle writeback is forwarded so the reader never sees stale data
      if (wb_valid_i && wb_addr_i == addr_i) begin
        data_o = wb_data_i;
      end else begin
        data_o = regs_i[addr_i];
        busy_o = busy_i[addr_i];
      end
    end
  end
endmodule

module tinker_regfile_sb #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 3,
  parameter int SP_INDEX = 31,
  parameter int SP_RESET = 524288
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*$clog2(NUM_REGS)-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       issue_valid,
  input  logic [$clog2(NUM_REGS)-1:0] issue_addr,
  output logic                       issue_ready,
  input  logic                       wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       flush,
  output logic [$clog2(NUM_REGS):0]  pending_cnt,
  output logic                       wb_orphan
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic [AW:0]                     pend_q, pend_d;
  logic                            orphan_q, orphan_d;

  logic iss_in, wb_in, wb_hit, iss_acc, iss_busy, wb_busy, same_addr, inc, dec;

  always_comb begin
    iss_in    = {1'b0, issue_addr} < (AW+1)'(NUM_REGS);
    wb_in     = {1'b0, wb_addr} < (AW+1)'(NUM_REGS);
    wb_hit    = wb_valid && wb_in;
    iss_busy  = iss_in && busy_q[issue_addr];
    wb_busy   = wb_hit && busy_q[wb_addr];
    same_addr = wb_hit && (wb_addr == issue_addr);
    issue_ready = iss_in && (!iss_busy || same_addr);
    iss_acc   = issue_valid && issue_ready && !flush;

    regs_d = regs_q;
    if (wb_hit) regs_d[wb_addr] = wb_data;

    // clear-then-set ordering makes a same-register issue win over its writeback
    busy_d = busy_q;
    if (wb_hit) busy_d[wb_addr] = 1'b0;
    if (iss_acc) busy_d[issue_addr] = 1'b1;
    if (flush) busy_d = '0;

    inc = iss_acc && !iss_busy;
    dec = wb_busy && !(iss_acc && same_addr);
    pend_d = flush ? '0 : pend_q + (AW+1)'(inc) - (AW+1)'(dec);

    orphan_d = orphan_q | (wb_hit && !busy_q[wb_addr] && (pend_q != '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs_q[r] <= (r == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
      busy_q   <= '0;
      pend_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      orphan_q <= orphan_d;
    end
  end

  assign pending_cnt = pend_q;
  assign wb_orphan   = orphan_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    tinker_regfile_sb_rdport #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .AW(AW)
    ) u_rd (
      .addr_i     (rd_addr[g*AW +: AW]),
      .regs_i     (regs_q),
      .busy_i     (busy_q),
      .wb_valid_i (wb_valid),
      .wb_addr_i  (wb_addr),
      .wb_data_i  (wb_data),
      .data_o     (rd_data[g*DATA_W +: DATA_W]),
      .busy_o     (rd_busy[g])
    );
  end
endmodule

// File: tb/tb_tinker_regfile_sb.sv
// Bench for tinker_regfile_sb: directed vector table, reset/orphan sequences,
// and randomized traffic against an array-based scoreboard model.

module tb_tinker_regfile_sb;
  localparam int DW = 64;
  localparam int NR = 32;
  localparam int AW = 5;

  logic            clk, reset;
  logic [3*AW-1:0] rd_addr;
  logic [3*DW-1:0] rd_data;
  logic [2:0]      rd_busy;
  logic            issue_valid, issue_ready;
  logic [AW-1:0]   issue_addr, wb_addr;
  logic            wb_valid, flush, wb_orphan;
  logic [DW-1:0]   wb_data;
  logic [AW:0]     pending_cnt;

  tinker_regfile_sb dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .pending_cnt(pending_cnt),
    .wb_orphan(wb_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_reg [NR];
  bit            m_busy[NR];
  bit            m_orph;

  function automatic int m_pend();
    int n = 0;
    for (int r = 0; r < NR; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_reg[r]  = (r == 31) ? 64'h80000 : 64'h0;
      m_busy[r] = 1'b0;
    end
    m_orph = 1'b0;
  endtask

  function automatic bit m_ready();
    return !m_busy[issue_addr] || (wb_valid && wb_addr == issue_addr);
  endfunction

  task automatic model_edge();
    bit rdy;
    rdy = m_ready();
    if (wb_valid) begin
      if (!m_busy[wb_addr] && m_pend() != 0) m_orph = 1'b1;
      m_reg[wb_addr]  = wb_data;
      m_busy[wb_addr] = 1'b0;
    end
    if (flush) begin
      for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
    end else if (issue_valid && rdy) begin
      m_busy[issue_addr] = 1'b1;
    end
  endtask

  task automatic model_check(input string tag);
    logic [AW-1:0] a;
    for (int p = 0; p < 3; p++) begin
      a = rd_addr[p*AW +: AW];
      if (wb_valid && wb_addr == a) begin
        chk($sformatf("%s rd_data%0d", tag, p), rd_data[p*DW +: DW], wb_data);
        chk($sformatf("%s rd_busy%0d", tag, p), 64'(rd_busy[p]), 64'd0);
      end else begin
        chk($sformatf("%s rd_data%0d", tag, p), rd_data[p*DW +: DW], m_reg[a]);
        chk($sformatf("%s rd_busy%0d", tag, p), 64'(rd_busy[p]), 64'(m_busy[a]));
      end
    end
    chk({tag, " issue_ready"}, 64'(issue_ready), 64'(m_ready()));
    chk({tag, " pending_cnt"}, 64'(pending_cnt), 64'(m_pend()));
    chk({tag, " wb_orphan"},   64'(wb_orphan), 64'(m_orph));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit iv, input int ia, input bit wv, input int wa,
                       input logic [DW-1:0] wd, input bit fl,
                       input int r0, input int r1, input int r2);
    issue_valid = iv; issue_addr = AW'(ia);
    wb_valid = wv; wb_addr = AW'(wa); wb_data = wd; flush = fl;
    rd_addr = {AW'(r2), AW'(r1), AW'(r0)};
  endtask

  task automatic finish_cycle();
    model_edge();
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit iv; int ia; bit wv; int wa; logic [DW-1:0] wd; bit fl;
    int r0; int r1; int r2;
    logic [DW-1:0] e_d0; logic [2:0] e_busy; bit e_rdy; int e_pend; bit e_orph;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // bypass
    tbl[0]  = '{0, 0, 1, 5, 64'h1234, 0,  5, 31, 0, 64'h1234, 3'b000, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 64'h0,    0,  5, 31, 0, 64'h1234, 3'b000, 1, 0, 0};
    // RAW scoreboard on reg8
    tbl[2]  = '{1, 8, 0, 0, 64'h0,    0,  8, 31, 0, 64'h0,    3'b000, 1, 0, 0};
    tbl[3]  = '{1, 8, 0, 0, 64'h0,    0,  8, 31, 0, 64'h0,    3'b001, 0, 1, 0};
    tbl[4]  = '{0, 8, 1, 8, 64'h4000000000000000, 0, 8, 31, 0,
                64'h4000000000000000, 3'b000, 1, 1, 0};
    // issue + wb same register (reg9)
    tbl[5]  = '{1, 9, 0, 0, 64'h0,    0,  8, 31, 0, 64'h4000000000000000, 3'b000, 1, 0, 0};
    tbl[6]  = '{1, 9, 1, 9, 64'h99,   0,  9, 31, 0, 64'h99,   3'b000, 1, 1, 0};
    // flush
    tbl[7]  = '{1, 2, 0, 0, 64'h0,    0,  9, 31, 0, 64'h99,   3'b001, 1, 1, 0};
    tbl[8]  = '{1, 3, 0, 0, 64'h0,    0,  2, 31, 0, 64'h0,    3'b001, 1, 2, 0};
    tbl[9]  = '{1, 4, 0, 0, 64'h0,    0,  3, 31, 0, 64'h0,    3'b001, 1, 3, 0};
    tbl[10] = '{1, 6, 1, 2, 64'hAA,   1,  2,  4, 9, 64'hAA,   3'b110, 1, 4, 0};
    tbl[11] = '{0, 6, 0, 0, 64'h0,    0,  2,  6, 4, 64'hAA,   3'b000, 1, 0, 0};
    // orphan
    tbl[12] = '{1, 10, 0, 0, 64'h0,   0, 10, 31, 0, 64'h0,    3'b000, 1, 0, 0};
    tbl[13] = '{0, 10, 1, 11, 64'h11, 0, 10, 31, 0, 64'h0,    3'b001, 0, 1, 0};
    tbl[14] = '{0, 10, 0, 0, 64'h0,   0, 11, 31, 0, 64'h11,   3'b000, 0, 1, 1};
    tbl[15] = '{0, 0, 1, 10, 64'h10,  0, 10, 31, 0, 64'h10,   3'b000, 1, 1, 1};
    tbl[16] = '{0, 0, 1, 11, 64'h22,  0, 11, 31, 0, 64'h22,   3'b000, 1, 0, 1};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 5, 31, 0);
    model_reset();
    #12 reset = 1'b0;
    @(posedge clk); #1;

    // reset mid-run: dirty reg5 and the scoreboard, then reset asynchronously
    drive(1, 7, 1, 5, 64'hFF, 0, 5, 31, 0);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0, 5, 31, 0);
    #1;
    chk("pre-reset reg5", rd_data[DW-1:0], 64'hFF);
    chk("pre-reset pend", 64'(pending_cnt), 64'd1);
    reset = 1'b1;
    #1;
    chk("reset rd0", rd_data[0*DW +: DW], 64'h0);
    chk("reset rd1", rd_data[1*DW +: DW], 64'h80000);
    chk("reset rd2", rd_data[2*DW +: DW], 64'h0);
    chk("reset busy", 64'(rd_busy), 64'd0);
    chk("reset pend", 64'(pending_cnt), 64'd0);
    chk("reset ready", 64'(issue_ready), 64'd1);
    #3 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].ia, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].fl,
            tbl[i].r0, tbl[i].r1, tbl[i].r2);
      #2;
      chk($sformatf("vec%0d rd_data0", i), rd_data[DW-1:0], tbl[i].e_d0);
      chk($sformatf("vec%0d rd_busy", i), 64'(rd_busy), 64'(tbl[i].e_busy));
      chk($sformatf("vec%0d issue_ready", i), 64'(issue_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d pending_cnt", i), 64'(pending_cnt), 64'(tbl[i].e_pend));
      chk($sformatf("vec%0d wb_orphan", i), 64'(wb_orphan), 64'(tbl[i].e_orph));
      finish_cycle();
    end

    // orphan is sticky until reset; a wb with nothing pending never sets it
    drive(0, 0, 0, 0, 0, 0, 11, 9, 2);
    #2;
    chk("sticky orphan", 64'(wb_orphan), 64'd1);
    chk("reg9 busy kept", 64'(rd_busy[1]), 64'd0);
    reset = 1'b1;
    #1;
    chk("orphan cleared", 64'(wb_orphan), 64'd0);
    #1 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    drive(0, 0, 1, 11, 64'h55, 0, 11, 31, 0);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0, 11, 31, 0);
    #2;
    chk("no orphan at pend0", 64'(wb_orphan), 64'd0);
    chk("reg11 written", rd_data[DW-1:0], 64'h55);
    finish_cycle();

    // randomized traffic; low addresses concentrate hazards
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 11),
            $urandom_range(0, 2) == 0, $urandom_range(0, 11),
            {$urandom, $urandom}, $urandom_range(0, 19) == 0,
            $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 31));
      #2;
      model_check($sformatf("rnd%0d", c));
      finish_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
